// File: rtl/kfmmc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kfmmc_pkg
// Description : Shared types and CRC7 helper for the MMC CMD line PHY.
// Revision    : 1.0 - initial release
// ============================================================================
package kfmmc_pkg;

    localparam logic [6:0] C_CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HUNT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } phy_state_t;

    // One serial step of x^7 + x^3 + 1
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic data_bit);
        logic fb;
        fb = crc[6] ^ data_bit;
        return {crc[5:0], 1'b0} ^ (fb ? C_CRC7_POLY : 7'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/kfmmc_crc7.sv
`default_nettype none
// ============================================================================
// Module      : kfmmc_crc7
// Description : Bit-serial CRC7 accumulator with synchronous clear and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module kfmmc_crc7
    import kfmmc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_bit,
    output logic [6:0] crc
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc <= 7'h00;
        end else if (clear) begin
            crc <= 7'h00;
        end else if (enable) begin
            crc <= crc7_next(crc, data_bit);
        end
    end

endmodule
`default_nettype wire

// File: rtl/kfmmc_command_line_phy.sv
`default_nettype none
// ============================================================================
// Module      : kfmmc_command_line_phy
// Description : Byte-at-a-time MMC CMD line engine: clock generation,
//               serialise/deserialise, running CRC7 and completion flags.
// Revision    : 1.0 - initial release
// ============================================================================
module kfmmc_command_line_phy
    import kfmmc_pkg::*;
#(
    parameter int CLOCK_DIVIDER     = 4,
    parameter int START_BIT_TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_communication,
    input  logic       command_io,
    input  logic       check_command_start_bit,
    input  logic       clear_command_crc,
    input  logic       clear_command_interrupt,
    input  logic       mask_command_interrupt,
    input  logic       set_send_command,
    input  logic [7:0] send_command,
    output logic [7:0] received_response,
    output logic [6:0] send_command_crc,
    output logic [6:0] received_response_crc,
    output logic       mmc_is_in_connecting,
    output logic       sent_command_interrupt,
    output logic       received_response_interrupt,
    output logic       mmc_clk,
    input  logic       mmc_cmd_in,
    output logic       mmc_cmd_out,
    output logic       mmc_cmd_oe
);

    localparam int DIV_W  = (CLOCK_DIVIDER > 2) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam int HUNT_W = $clog2(START_BIT_TIMEOUT + 1);
    localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(CLOCK_DIVIDER - 1);
    localparam logic [HUNT_W-1:0] C_HUNT_LAST = HUNT_W'(START_BIT_TIMEOUT - 1);

    phy_state_t        r_state;
    logic              r_is_rx;
    logic              r_check;
    logic              r_clear_crc;
    logic              r_set_send;
    logic              r_load_second;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_cnt;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [HUNT_W-1:0] r_hunt_cnt;
    logic              r_hunt_hit;
    logic              r_tx_flag;
    logic              r_rx_flag;

    logic w_clocking;
    logic w_phase_end;
    logic w_rise;
    logic w_crc_clear;

    assign w_clocking  = (r_state == ST_HUNT) || (r_state == ST_SHIFT);
    assign w_phase_end = w_clocking && (r_div_cnt == C_DIV_LAST);
    assign w_rise      = w_phase_end && !mmc_clk;
    assign w_crc_clear = (r_state == ST_LOAD) && r_load_second && r_clear_crc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state              <= ST_IDLE;
            r_is_rx              <= 1'b0;
            r_check              <= 1'b0;
            r_clear_crc          <= 1'b0;
            r_set_send           <= 1'b0;
            r_load_second        <= 1'b0;
            r_shift              <= 8'hFF;
            r_bit_cnt            <= 3'd0;
            r_div_cnt            <= '0;
            r_hunt_cnt           <= '0;
            r_hunt_hit           <= 1'b0;
            received_response    <= 8'hFF;
            mmc_is_in_connecting <= 1'b0;
            mmc_clk              <= 1'b0;
            mmc_cmd_out          <= 1'b1;
            mmc_cmd_oe           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_communication) begin
                        r_state              <= ST_LOAD;
                        r_is_rx              <= command_io;
                        r_check              <= check_command_start_bit;
                        r_clear_crc          <= clear_command_crc;
                        r_set_send           <= set_send_command;
                        r_load_second        <= 1'b0;
                        mmc_is_in_connecting <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!r_load_second) begin
                        r_load_second <= 1'b1;
                    end else begin
                        r_shift    <= (!r_is_rx && r_set_send) ? send_command : 8'hFF;
                        r_div_cnt  <= '0;
                        r_hunt_cnt <= '0;
                        r_hunt_hit <= 1'b0;
                        mmc_clk    <= 1'b0;
                        mmc_cmd_oe <= !r_is_rx;
                        mmc_cmd_out <= (!r_is_rx && r_set_send) ? send_command[7] : 1'b1;
                        if (r_is_rx && r_check) begin
                            r_state <= ST_HUNT;
                        end else begin
                            r_state   <= ST_SHIFT;
                            r_bit_cnt <= 3'd7;
                        end
                    end
                end
                ST_HUNT: begin
                    r_div_cnt <= w_phase_end ? '0 : r_div_cnt + 1'b1;
                    if (w_phase_end) begin
                        if (!mmc_clk) begin
                            mmc_clk <= 1'b1;
                            if (!mmc_cmd_in) begin
                                r_hunt_hit <= 1'b1;
                                r_shift    <= {r_shift[6:0], 1'b0};
                            end
                        end else if (r_hunt_hit) begin
                            mmc_clk   <= 1'b0;
                            r_state   <= ST_SHIFT;
                            r_bit_cnt <= 3'd6;
                        end else if (r_hunt_cnt == C_HUNT_LAST) begin
                            mmc_clk <= 1'b0;
                            r_shift <= 8'hFF;
                            r_state <= ST_DONE;
                        end else begin
                            mmc_clk    <= 1'b0;
                            r_hunt_cnt <= r_hunt_cnt + 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_div_cnt <= w_phase_end ? '0 : r_div_cnt + 1'b1;
                    if (w_phase_end) begin
                        if (!mmc_clk) begin
                            mmc_clk <= 1'b1;
                            if (r_is_rx) begin
                                r_shift <= {r_shift[6:0], mmc_cmd_in};
                            end
                        end else if (r_bit_cnt == 3'd0) begin
                            mmc_clk     <= 1'b0;
                            mmc_cmd_out <= 1'b1;
                            mmc_cmd_oe  <= 1'b0;
                            r_state     <= ST_DONE;
                        end else begin
                            // End of high phase: present the next transmit bit
                            mmc_clk   <= 1'b0;
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            if (!r_is_rx) begin
                                r_shift     <= {r_shift[6:0], 1'b1};
                                mmc_cmd_out <= r_shift[6];
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (r_is_rx) begin
                        received_response <= r_shift;
                    end
                    mmc_clk              <= 1'b0;
                    mmc_cmd_out          <= 1'b1;
                    mmc_cmd_oe           <= 1'b0;
                    mmc_is_in_connecting <= 1'b0;
                    r_state              <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Completion set takes priority over a coincident clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_flag <= 1'b0;
            r_rx_flag <= 1'b0;
        end else begin
            if ((r_state == ST_DONE) && !r_is_rx) begin
                r_tx_flag <= 1'b1;
            end else if (clear_command_interrupt) begin
                r_tx_flag <= 1'b0;
            end
            if ((r_state == ST_DONE) && r_is_rx) begin
                r_rx_flag <= 1'b1;
            end else if (clear_command_interrupt) begin
                r_rx_flag <= 1'b0;
            end
        end
    end

    assign sent_command_interrupt      = r_tx_flag & ~mask_command_interrupt;
    assign received_response_interrupt = r_rx_flag & ~mask_command_interrupt;

    kfmmc_crc7 u_tx_crc (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_crc_clear && !r_is_rx),
        .enable   (w_rise && (r_state == ST_SHIFT) && !r_is_rx),
        .data_bit (r_shift[7]),
        .crc      (send_command_crc)
    );

    kfmmc_crc7 u_rx_crc (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_crc_clear && r_is_rx),
        .enable   (w_rise && r_is_rx && ((r_state == ST_SHIFT) || !mmc_cmd_in)),
        .data_bit (mmc_cmd_in),
        .crc      (received_response_crc)
    );

endmodule
`default_nettype wire

// File: tb/tb_kfmmc_command_line_phy.sv
`default_nettype none
// ============================================================================
// Module      : tb_kfmmc_command_line_phy
// Description : Self-checking bench for the MMC CMD line PHY with a
//               polynomial-division CRC reference and randomized bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_kfmmc_command_line_phy;

    localparam int DIV = 2;
    localparam int TMO = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_communication = 1'b0;
    logic       command_io = 1'b0;
    logic       check_command_start_bit = 1'b0;
    logic       clear_command_crc = 1'b0;
    logic       clear_command_interrupt = 1'b0;
    logic       mask_command_interrupt = 1'b0;
    logic       set_send_command = 1'b0;
    logic [7:0] send_command = 8'h00;
    logic [7:0] received_response;
    logic [6:0] send_command_crc;
    logic [6:0] received_response_crc;
    logic       mmc_is_in_connecting;
    logic       sent_command_interrupt;
    logic       received_response_interrupt;
    logic       mmc_clk;
    logic       mmc_cmd_in;
    logic       mmc_cmd_out;
    logic       mmc_cmd_oe;

    kfmmc_command_line_phy #(.CLOCK_DIVIDER(DIV), .START_BIT_TIMEOUT(TMO)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .start_communication         (start_communication),
        .command_io                  (command_io),
        .check_command_start_bit     (check_command_start_bit),
        .clear_command_crc           (clear_command_crc),
        .clear_command_interrupt     (clear_command_interrupt),
        .mask_command_interrupt      (mask_command_interrupt),
        .set_send_command            (set_send_command),
        .send_command                (send_command),
        .received_response           (received_response),
        .send_command_crc            (send_command_crc),
        .received_response_crc       (received_response_crc),
        .mmc_is_in_connecting        (mmc_is_in_connecting),
        .sent_command_interrupt      (sent_command_interrupt),
        .received_response_interrupt (received_response_interrupt),
        .mmc_clk                     (mmc_clk),
        .mmc_cmd_in                  (mmc_cmd_in),
        .mmc_cmd_out                 (mmc_cmd_out),
        .mmc_cmd_oe                  (mmc_cmd_oe)
    );

    always #5 clock = ~clock;

    // Card side: count mmc_clk pulses, log driven bits, replay a bit stream
    int          pulse_cnt = 0;
    int          rx_base   = 0;
    int          rx_len    = 0;
    logic [63:0] tx_log    = 64'h0;
    logic [127:0] rx_stream = '1;
    logic [6:0]  rx_idx;

    always @(posedge mmc_clk) begin
        pulse_cnt <= pulse_cnt + 1;
        if (mmc_cmd_oe) tx_log <= {tx_log[62:0], mmc_cmd_out};
    end

    assign rx_idx     = 7'(pulse_cnt - rx_base);
    assign mmc_cmd_in = ((pulse_cnt - rx_base) < rx_len) ? rx_stream[rx_idx] : 1'b1;

    // Reference model state
    bit         tx_msg[$];
    bit         rx_msg[$];
    logic [7:0] model_rx = 8'hFF;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Remainder of M(x)*x^7 divided by x^7+x^3+1, by textbook long division
    function automatic logic [6:0] model_crc(input bit rx_dir);
        logic [7:0] rem;
        int         n;
        bit         b;
        rem = 8'h00;
        n   = rx_dir ? rx_msg.size() : tx_msg.size();
        for (int i = 0; i < n + 7; i++) begin
            b = (i < n) ? (rx_dir ? rx_msg[i] : tx_msg[i]) : 1'b0;
            rem = {rem[6:0], b};
            if (rem[7]) rem = rem ^ 8'h89;
        end
        return rem[6:0];
    endfunction

    function automatic bit stream_bit(input int j);
        return (j < rx_len) ? rx_stream[7'(j)] : 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            if (!mmc_is_in_connecting) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // One byte transfer; model computes pulses, bits, received byte and CRCs
    task automatic run_byte(input logic io, input logic chk, input logic clr, input logic setd,
                            input logic [7:0] data, input int ones, input bit with_data,
                            input bit chk_irq, input bit mid_start, input string tag,
                            output int pulses);
        bit         timed_out;
        int         exp_pulses;
        int         p;
        logic [7:0] exp_tx;
        bit         b;
        rx_len    = 0;
        rx_stream = '1;
        if (io) begin
            for (int i = 0; i < ones; i++) begin
                rx_stream[7'(rx_len)] = 1'b1;
                rx_len++;
            end
            if (with_data) begin
                for (int i = 7; i >= 0; i--) begin
                    rx_stream[7'(rx_len)] = data[i];
                    rx_len++;
                end
            end
        end
        @(negedge clock);
        rx_base                 = pulse_cnt;
        command_io              = io;
        check_command_start_bit = chk;
        clear_command_crc       = clr;
        set_send_command        = setd;
        send_command            = data;
        start_communication     = 1'b1;
        if (chk_irq) clear_command_interrupt = 1'b1;
        @(negedge clock);
        start_communication     = 1'b0;
        if (chk_irq) clear_command_interrupt = 1'b0;
        check({tag, " busy_after_start"}, mmc_is_in_connecting, 1'b1);
        if (mid_start) begin
            repeat (10) @(negedge clock);
            command_io          = ~io;
            start_communication = 1'b1;
            @(negedge clock);
            start_communication = 1'b0;
            command_io          = io;
        end
        wait_idle(timed_out);
        check({tag, " timeout"}, timed_out, 1'b0);

        exp_tx = 8'hFF;
        if (!io) begin
            if (clr) tx_msg.delete();
            exp_pulses = 8;
            exp_tx     = setd ? data : 8'hFF;
            for (int i = 7; i >= 0; i--) tx_msg.push_back(exp_tx[i]);
        end else begin
            if (clr) rx_msg.delete();
            p = 0;
            if (chk) while (p < TMO && stream_bit(p)) p++;
            if (chk && p == TMO) begin
                exp_pulses = TMO;
                model_rx   = 8'hFF;
            end else begin
                exp_pulses = p + 8;
                for (int j = 0; j < 8; j++) begin
                    b        = stream_bit(p + j);
                    model_rx = {model_rx[6:0], b};
                    rx_msg.push_back(b);
                end
            end
        end
        pulses = pulse_cnt - rx_base;
        check({tag, " pulses"}, pulses, exp_pulses);
        if (!io) check({tag, " tx_bits"}, tx_log[7:0], exp_tx);
        check({tag, " rx_byte"}, received_response, model_rx);
        check({tag, " tx_crc"}, send_command_crc, model_crc(1'b0));
        check({tag, " rx_crc"}, received_response_crc, model_crc(1'b1));
        check({tag, " idle_lines"}, {mmc_clk, mmc_cmd_oe, mmc_cmd_out}, 3'b001);
        if (chk_irq) begin
            check({tag, " irq"}, {sent_command_interrupt, received_response_interrupt},
                  io ? 2'b01 : 2'b10);
        end
        if (mid_start) begin
            repeat (6) @(negedge clock);
            check({tag, " stays_idle"}, mmc_is_in_connecting, 1'b0);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear_command_interrupt = 1'b1;
        @(negedge clock);
        clear_command_interrupt = 1'b0;
    endtask

    int  pulses;
    bit  tmo_flag;
    logic [7:0] cmd0 [5];

    initial begin
        cmd0[0] = 8'h40; cmd0[1] = 8'h00; cmd0[2] = 8'h00; cmd0[3] = 8'h00; cmd0[4] = 8'h00;
        repeat (3) @(negedge clock);
        check("reset_lines", {mmc_clk, mmc_cmd_out, mmc_cmd_oe}, 3'b010);
        check("reset_rx", received_response, 8'hFF);
        check("reset_crcs", {send_command_crc, received_response_crc}, 14'h0);
        check("reset_busy_irq", {mmc_is_in_connecting, sent_command_interrupt,
                                 received_response_interrupt}, 3'b000);
        reset = 1'b0;

        // CMD0 transmit
        for (int i = 0; i < 5; i++) begin
            run_byte(1'b0, 1'b0, (i == 0), 1'b1, cmd0[i], 0, 1'b0, 1'b1, 1'b0,
                     $sformatf("cmd0_tx%0d", i), pulses);
        end
        check("cmd0_tx_crc_4a", send_command_crc, 7'h4A);

        // Receive with start-bit hunt: ten idle 1s then 0x01
        run_byte(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 10, 1'b1, 1'b1, 1'b0, "hunt_rx", pulses);
        check("hunt_rx_18_pulses", pulses, 18);
        check("hunt_rx_value", received_response, 8'h01);

        // Hunt timeout with line stuck high
        run_byte(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, "stuck_rx", pulses);
        check("stuck_rx_64_pulses", pulses, 64);

        // CMD0 receive without hunt
        for (int i = 0; i < 5; i++) begin
            run_byte(1'b1, 1'b0, (i == 0), 1'b0, cmd0[i], 0, 1'b1, 1'b1, 1'b0,
                     $sformatf("cmd0_rx%0d", i), pulses);
        end
        check("cmd0_rx_crc_4a", received_response_crc, 7'h4A);

        // Interrupt mask / clear / coincident set
        pulse_clear();
        mask_command_interrupt = 1'b1;
        run_byte(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 1'b0, 1'b0, 1'b0, "mask_tx", pulses);
        check("masked_irq", sent_command_interrupt, 1'b0);
        mask_command_interrupt = 1'b0;
        #1;
        check("unmasked_irq", sent_command_interrupt, 1'b1);
        pulse_clear();
        check("cleared_irq", sent_command_interrupt, 1'b0);
        clear_command_interrupt = 1'b1;
        run_byte(1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 0, 1'b0, 1'b0, 1'b0, "set_vs_clear", pulses);
        check("set_wins_over_clear", sent_command_interrupt, 1'b1);
        clear_command_interrupt = 1'b0;

        // Randomized bytes in both directions
        for (int i = 0; i < 12; i++) begin
            run_byte(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                     8'($urandom), int'($urandom_range(0, 6)), 1'b1, 1'b1, 1'b0,
                     $sformatf("rand%0d", i), pulses);
        end

        // Start pulsed mid-transfer must be ignored
        run_byte(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 1'b0, 1'b1, 1'b1, "mid_start", pulses);

        // Reset during bit 3 of a transmit byte
        pulse_clear();
        @(negedge clock);
        rx_base             = pulse_cnt;
        rx_len              = 0;
        command_io          = 1'b0;
        set_send_command    = 1'b1;
        send_command        = 8'h5A;
        start_communication = 1'b1;
        @(negedge clock);
        start_communication = 1'b0;
        tmo_flag = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clock);
            if ((pulse_cnt - rx_base) == 3 && !mmc_clk) begin
                tmo_flag = 1'b0;
                break;
            end
        end
        check("reset_wait_timeout", tmo_flag, 1'b0);
        reset = 1'b1;
        #1;
        check("midreset_lines", {mmc_clk, mmc_cmd_oe, mmc_cmd_out}, 3'b001);
        check("midreset_busy", mmc_is_in_connecting, 1'b0);
        check("midreset_irq", {sent_command_interrupt, received_response_interrupt}, 2'b00);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        tx_msg.delete();
        rx_msg.delete();
        model_rx = 8'hFF;
        repeat (20) @(negedge clock);
        check("postreset_irq", {sent_command_interrupt, received_response_interrupt}, 2'b00);
        check("postreset_state", {received_response, send_command_crc, received_response_crc},
              {8'hFF, model_crc(1'b0), model_crc(1'b1)});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
